// File: rtl/reset_seq_ctrl_if.sv
// Control/status bundle of the reset sequencer: timing config, software
// re-reset handshake and the per-channel active-low resets.
interface reset_seq_ctrl_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
);
    logic [CNT_W-1:0] hold_cyc;
    logic [CNT_W-1:0] gap_cyc;
    logic             sw_req;
    logic             sw_ack;
    logic [N_CH-1:0]  ch_rst_n;
    logic             busy;
    logic             seq_done;

    modport master (
        output hold_cyc,
        output gap_cyc,
        output sw_req,
        input  sw_ack,
        input  ch_rst_n,
        input  busy,
        input  seq_done
    );

    modport slave (
        input  hold_cyc,
        input  gap_cyc,
        input  sw_req,
        output sw_ack,
        output ch_rst_n,
        output busy,
        output seq_done
    );
endinterface

// File: rtl/reset_seq_ctrl.sv
// N-channel reset sequencer: holds all channels for H cycles, then releases them
// in channel order every G cycles; restarts on rst or an accepted sw_req in IDLE.
module reset_seq_ctrl #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    reset_seq_ctrl_if.slave ctl
);
    localparam int               IDX_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);
    localparam logic [N_CH-1:0]  CH_ONE   = N_CH'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        IDLE    = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] hold_lat;
    logic [CNT_W-1:0] hold_lat_nxt;
    logic [CNT_W-1:0] gap_lat;
    logic [CNT_W-1:0] gap_lat_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic [N_CH-1:0]  ch_rst_n_q;
    logic [N_CH-1:0]  ch_rst_n_nxt;
    logic             ack_q;
    logic             ack_nxt;
    logic             done_q;
    logic             done_nxt;

    logic [CNT_W-1:0] hold_eff;
    logic [CNT_W-1:0] gap_eff;
    logic [CNT_W-1:0] limit;
    logic             phase_end;

    // Zero-valued timing config is promoted to one cycle.
    assign hold_eff = (ctl.hold_cyc == '0) ? CNT_ONE : ctl.hold_cyc;
    assign gap_eff  = (ctl.gap_cyc  == '0) ? CNT_ONE : ctl.gap_cyc;

    // cnt holds the number of edges seen in the current phase; a phase ends
    // at the edge where that count reaches the latched limit, so it never wraps.
    assign limit     = (state == HOLD) ? hold_lat : gap_lat;
    assign phase_end = (cnt == limit);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        idx_nxt      = idx;
        ch_rst_n_nxt = ch_rst_n_q;
        hold_lat_nxt = hold_lat;
        gap_lat_nxt  = gap_lat;
        ack_nxt      = 1'b0;
        done_nxt     = 1'b0;

        case (state)
            HOLD, RELEASE: begin
                if (phase_end) begin
                    ch_rst_n_nxt = ch_rst_n_q | (CH_ONE << idx);
                    cnt_nxt      = CNT_ONE;
                    if (idx == LAST_IDX) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = RELEASE;
                        idx_nxt   = idx + IDX_W'(1);
                    end
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            IDLE: begin
                if (ctl.sw_req) begin
                    state_nxt    = HOLD;
                    cnt_nxt      = '0;
                    idx_nxt      = '0;
                    ch_rst_n_nxt = '0;
                    hold_lat_nxt = hold_eff;
                    gap_lat_nxt  = gap_eff;
                    ack_nxt      = 1'b1;
                end
            end
            default: begin
                // Unreachable encoding: fall back to a fresh, fully-asserted hold.
                state_nxt    = HOLD;
                cnt_nxt      = '0;
                idx_nxt      = '0;
                ch_rst_n_nxt = '0;
                hold_lat_nxt = hold_eff;
                gap_lat_nxt  = gap_eff;
            end
        endcase
    end

    // rst overrides everything, including a same-cycle sw_req in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HOLD;
            cnt        <= '0;
            idx        <= '0;
            ch_rst_n_q <= '0;
            hold_lat   <= hold_eff;
            gap_lat    <= gap_eff;
            ack_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            ch_rst_n_q <= ch_rst_n_nxt;
            hold_lat   <= hold_lat_nxt;
            gap_lat    <= gap_lat_nxt;
            ack_q      <= ack_nxt;
            done_q     <= done_nxt;
        end
    end

    assign ctl.ch_rst_n = ch_rst_n_q;
    assign ctl.busy     = ~(&ch_rst_n_q);
    assign ctl.sw_ack   = ack_q;
    assign ctl.seq_done = done_q;
endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Bench for reset_seq_ctrl: a 4-channel and a 1-channel instance checked every
// cycle against an edge-count model, plus directed timing points.
module tb_reset_seq_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    reset_seq_ctrl_if #(.N_CH(4), .CNT_W(8)) bus4();
    reset_seq_ctrl_if #(.N_CH(1), .CNT_W(8)) bus1();

    reset_seq_ctrl #(.N_CH(4), .CNT_W(8)) dut4 (.clk(clk), .rst(rst), .ctl(bus4));
    reset_seq_ctrl #(.N_CH(1), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .ctl(bus1));

    // Model per instance: latched H/G, channel count, index of the last edge
    // processed since the sequence started (-1 right after a load), ack flag.
    int mh [2] = '{1, 1};
    int mg [2] = '{1, 1};
    int mn [2] = '{4, 1};
    int me [2] = '{-1, -1};
    bit mack [2] = '{1'b0, 1'b0};

    function automatic int total(int d);
        return mh[d] + (mn[d] - 1) * mg[d];
    endfunction

    function automatic logic [31:0] exp_ch(int d);
        logic [31:0] v = '0;
        for (int i = 0; i < mn[d]; i++)
            if (me[d] >= mh[d] + i * mg[d]) v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int d, input int h, input int g);
        mh[d] = (h == 0) ? 1 : h;
        mg[d] = (g == 0) ? 1 : g;
        me[d] = -1;
    endtask

    task automatic step();
        int h, g;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            h = (d == 0) ? int'(bus4.hold_cyc) : int'(bus1.hold_cyc);
            g = (d == 0) ? int'(bus4.gap_cyc)  : int'(bus1.gap_cyc);
            mack[d] = 1'b0;
            if (rst) begin
                load(d, h, g);
            end else if (bus4.sw_req && me[d] >= total(d)) begin
                load(d, h, g);
                mack[d] = 1'b1;
            end else if (me[d] < 100000) begin
                me[d]++;
            end
        end
        #1;
        chk("ch4",   32'(bus4.ch_rst_n), exp_ch(0));
        chk("busy4", 32'(bus4.busy),     32'(me[0] < total(0)));
        chk("ack4",  32'(bus4.sw_ack),   32'(mack[0]));
        chk("done4", 32'(bus4.seq_done), 32'(me[0] == total(0)));
        chk("ch1",   32'(bus1.ch_rst_n), exp_ch(1));
        chk("busy1", 32'(bus1.busy),     32'(me[1] < total(1)));
        chk("ack1",  32'(bus1.sw_ack),   32'(mack[1]));
        chk("done1", 32'(bus1.seq_done), 32'(me[1] == total(1)));
    endtask

    // sw_req is a single shared request line driven into both instances.
    always_comb bus1.sw_req = bus4.sw_req;

    logic [3:0] pon_tab [0:10];
    logic [3:0] zero_tab [0:4];
    int got;
    int found;

    initial begin
        pon_tab = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h3, 4'h3, 4'h7, 4'h7, 4'hF, 4'hF};
        zero_tab = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF};

        rst = 1'b1;
        bus4.sw_req = 1'b0;
        bus4.hold_cyc = 8'd3;
        bus4.gap_cyc = 8'd2;
        bus1.hold_cyc = 8'd255;
        bus1.gap_cyc = 8'd0;

        // Power-on, with hold_cyc changed mid-HOLD to confirm latching.
        for (int k = 0; k < 5; k++) step();
        chk("rst_ch", 32'(bus4.ch_rst_n), 32'h0);
        chk("rst_busy", 32'(bus4.busy), 32'h1);
        rst = 1'b0;
        for (int e = 0; e < 11; e++) begin
            step();
            chk($sformatf("pon_e%0d", e), 32'(bus4.ch_rst_n), 32'(pon_tab[e]));
            chk($sformatf("pon_done_e%0d", e), 32'(bus4.seq_done), 32'(e == 9));
            if (e == 1) bus4.hold_cyc = 8'd10;
        end

        // Zero configuration behaves as H=1, G=1.
        bus4.hold_cyc = 8'd0;
        bus4.gap_cyc = 8'd0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int e = 0; e < 5; e++) begin
            step();
            chk($sformatf("zero_e%0d", e), 32'(bus4.ch_rst_n), 32'(zero_tab[e]));
        end

        // Software re-reset from IDLE; new H/G latched at acceptance.
        bus4.hold_cyc = 8'd3;
        bus4.gap_cyc = 8'd2;
        bus4.sw_req = 1'b1;
        step();
        chk("sw_ack", 32'(bus4.sw_ack), 32'h1);
        chk("sw_ch0", 32'(bus4.ch_rst_n), 32'h0);
        bus4.sw_req = 1'b0;
        for (int e = 0; e < 11; e++) begin
            step();
            chk($sformatf("sw_e%0d", e), 32'(bus4.ch_rst_n), 32'(pon_tab[e]));
        end

        // Request raised during RELEASE is held until IDLE accepts it.
        bus4.sw_req = 1'b1;
        step();
        bus4.sw_req = 1'b0;
        for (int k = 0; k < 5; k++) step();
        bus4.sw_req = 1'b1;
        got = 0;
        for (int k = 0; k < 30 && got == 0; k++) begin
            step();
            if (bus4.sw_ack) got = 1;
        end
        chk("rel_req_ack", 32'(got), 32'h1);
        bus4.sw_req = 1'b0;

        // Reset in the middle of a release.
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            step();
            if (bus4.ch_rst_n == 4'b0011) found = 1;
        end
        chk("mid_found", 32'(found), 32'h1);
        rst = 1'b1;
        step();
        chk("mid_ch", 32'(bus4.ch_rst_n), 32'h0);
        chk("mid_busy", 32'(bus4.busy), 32'h1);
        rst = 1'b0;
        for (int e = 0; e < 11; e++) begin
            step();
            chk($sformatf("mid_e%0d", e), 32'(bus4.ch_rst_n), 32'(pon_tab[e]));
        end

        // rst together with sw_req in IDLE: no acknowledge.
        rst = 1'b1;
        bus4.sw_req = 1'b1;
        step();
        chk("rst_req_ack", 32'(bus4.sw_ack), 32'h0);
        chk("rst_req_ch", 32'(bus4.ch_rst_n), 32'h0);
        rst = 1'b0;
        bus4.sw_req = 1'b0;

        // Single channel with the maximum hold time.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int e = 0; e < 257; e++) begin
            step();
            if (e == 254) chk("n1_e254", 32'(bus1.ch_rst_n), 32'h0);
            if (e == 255) begin
                chk("n1_e255", 32'(bus1.ch_rst_n), 32'h1);
                chk("n1_done", 32'(bus1.seq_done), 32'h1);
            end
        end

        // Randomized config, requests and occasional resets.
        for (int k = 0; k < 800; k++) begin
            rst = ($urandom_range(0, 49) == 0);
            bus4.sw_req = ($urandom_range(0, 3) == 0);
            bus4.hold_cyc = 8'($urandom_range(0, 7));
            bus4.gap_cyc = 8'($urandom_range(0, 7));
            bus1.hold_cyc = 8'($urandom_range(0, 7));
            bus1.gap_cyc = 8'($urandom_range(0, 7));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
